// File: rtl/req_pending_tracker.sv
// Per-requester pending-request tracker feeding the grant stage.
// Each requester queues pulses as a count, strobes req, then waits for grnt with retry on timeout.
//
// state | meaning
// IDLE  | nothing pending, req low
// ISSUE | req strobe high this cycle, timer restarts
// WAIT  | awaiting grnt, timer counting toward retry
module req_pending_tracker #(
  parameter int MAX_REQ     = 4,
  parameter int CNT_W       = 3,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAX_REQ-1:0]       req_pulse,
  input  logic [MAX_REQ-1:0]       grnt,
  output logic [MAX_REQ-1:0]       req,
  output logic [MAX_REQ*CNT_W-1:0] pend_cnt,
  output logic [MAX_REQ-1:0]       ovf,
  output logic [MAX_REQ-1:0]       starve,
  output logic [MAX_REQ-1:0]       spur_gnt,
  input  logic                     clr_err
);

  localparam int                 TMR_W    = $clog2(GNT_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  for (genvar i = 0; i < MAX_REQ; i++) begin : g_req
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             dec, inc, drop, timeout, spur;
    logic             req_q, req_nxt;
    logic             ovf_q, ovf_nxt;
    logic             starve_q, starve_nxt;
    logic             spur_q, spur_nxt;

    // A grant in the same cycle as a pulse frees a slot, so a full counter still accepts it.
    always_comb begin
      dec     = (state == WAIT) && grnt[i];
      drop    = req_pulse[i] && (cnt == CNT_MAX) && !dec;
      inc     = req_pulse[i] && !drop;
      cnt_nxt = cnt + CNT_W'(inc) - CNT_W'(dec);
      timeout = (state == WAIT) && !grnt[i] && (timer == TMR_LAST);
      spur    = grnt[i] && (state != WAIT);
    end

    always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      case (state)
        IDLE: begin
          if (cnt != '0) state_nxt = ISSUE;
        end
        ISSUE: begin
          timer_nxt = '0;
          state_nxt = WAIT;
        end
        WAIT: begin
          timer_nxt = timer + TMR_W'(1);
          if (grnt[i])              state_nxt = (cnt_nxt != '0) ? ISSUE : IDLE;
          else if (timer == TMR_LAST) state_nxt = ISSUE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_comb begin
      req_nxt    = (state_nxt == ISSUE);
      ovf_nxt    = drop    || (ovf_q    && !clr_err);
      starve_nxt = timeout || (starve_q && !clr_err);
      spur_nxt   = spur    || (spur_q   && !clr_err);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= IDLE;
        cnt      <= '0;
        timer    <= '0;
        req_q    <= 1'b0;
        ovf_q    <= 1'b0;
        starve_q <= 1'b0;
        spur_q   <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        timer    <= timer_nxt;
        req_q    <= req_nxt;
        ovf_q    <= ovf_nxt;
        starve_q <= starve_nxt;
        spur_q   <= spur_nxt;
      end
    end

    assign req[i]                      = req_q;
    assign pend_cnt[i*CNT_W +: CNT_W]  = cnt;
    assign ovf[i]                      = ovf_q;
    assign starve[i]                   = starve_q;
    assign spur_gnt[i]                 = spur_q;
  end

endmodule

// File: tb/tb_req_pending_tracker.sv
// Bench for req_pending_tracker: directed latency/boundary cases plus random traffic,
// all compared cycle by cycle against a count/phase reference model.
module tb_req_pending_tracker;
  localparam int N    = 4;
  localparam int W    = 3;
  localparam int TO   = 16;
  localparam int MAXC = 7;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_pulse, grnt, req, ovf, starve, spur_gnt;
  logic [N*W-1:0] pend_cnt;
  logic           clr_err;
  logic [N-1:0]   prev_req;

  int total = 0;
  int bad   = 0;

  int m_cnt[N];
  int m_ph[N];
  int m_tmr[N];
  bit m_ovf[N], m_st[N], m_sp[N], m_req[N];

  always #5 clk = ~clk;

  req_pending_tracker #(.MAX_REQ(N), .CNT_W(W), .GNT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_pulse(req_pulse), .grnt(grnt), .req(req),
    .pend_cnt(pend_cnt), .ovf(ovf), .starve(starve), .spur_gnt(spur_gnt),
    .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    logic [N*W-1:0] v;
    v = pend_cnt;
    return 32'(v[i*W +: W]);
  endfunction

  // Advance the model with the current inputs, clock the DUT, then compare everything.
  task automatic cycle();
    int ncnt, nph, ntmr;
    bit dec, drop, tmo;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_ph[i] = P_IDLE; m_tmr[i] = 0;
        m_ovf[i] = 0; m_st[i] = 0; m_sp[i] = 0; m_req[i] = 0;
      end else begin
        dec  = (m_ph[i] == P_WAIT) && grnt[i];
        drop = req_pulse[i] && (m_cnt[i] == MAXC) && !dec;
        ncnt = m_cnt[i] + ((req_pulse[i] && !drop) ? 1 : 0) - (dec ? 1 : 0);
        tmo  = 0;
        nph  = m_ph[i];
        ntmr = m_tmr[i];
        if (m_ph[i] == P_IDLE) begin
          if (m_cnt[i] != 0) nph = P_ISSUE;
        end else if (m_ph[i] == P_ISSUE) begin
          nph = P_WAIT; ntmr = 0;
        end else begin
          if (grnt[i]) nph = (ncnt != 0) ? P_ISSUE : P_IDLE;
          else if (m_tmr[i] == TO - 1) begin nph = P_ISSUE; tmo = 1; end
          else ntmr = m_tmr[i] + 1;
        end
        m_ovf[i] = drop || (m_ovf[i] && !clr_err);
        m_st[i]  = tmo  || (m_st[i]  && !clr_err);
        m_sp[i]  = (grnt[i] && m_ph[i] != P_WAIT) || (m_sp[i] && !clr_err);
        m_cnt[i] = ncnt;
        m_ph[i]  = nph;
        m_tmr[i] = ntmr;
        m_req[i] = (nph == P_ISSUE);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("req%0d", i),    32'(req[i]),      32'(m_req[i]));
      chk($sformatf("cnt%0d", i),    cnt_of(i),        32'(m_cnt[i]));
      chk($sformatf("ovf%0d", i),    32'(ovf[i]),      32'(m_ovf[i]));
      chk($sformatf("starve%0d", i), 32'(starve[i]),   32'(m_st[i]));
      chk($sformatf("spur%0d", i),   32'(spur_gnt[i]), 32'(m_sp[i]));
    end
  endtask

  // Grant stage that echoes each req strobe one cycle later.
  task automatic step_echo();
    cycle();
    grnt     = prev_req;
    prev_req = req;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_pulse = '0; grnt = '0; clr_err = 1'b0;
    cycle();
    rst = 1'b0;
    prev_req = '0;
  endtask

  initial begin
    do_reset();
    chk("rst_req", 32'(req), 0);
    chk("rst_cnt", 32'(pend_cnt), 0);
    chk("rst_flags", 32'({ovf, starve, spur_gnt}), 0);

    // single pulse, echoed grant
    req_pulse = 4'b0001;
    step_echo();
    chk("t1_cnt_t1", cnt_of(0), 1);
    chk("t1_req_t1", 32'(req[0]), 0);
    req_pulse = '0;
    step_echo();
    chk("t1_req_t2", 32'(req[0]), 1);
    step_echo();
    chk("t1_cnt_t3", cnt_of(0), 1);
    chk("t1_req_t3", 32'(req[0]), 0);
    step_echo();
    chk("t1_cnt_t4", cnt_of(0), 0);
    for (int k = 0; k < 4; k++) step_echo();

    // three back-to-back pulses on requester 2
    do_reset();
    req_pulse = 4'b0100;
    for (int k = 1; k <= 9; k++) begin
      step_echo();
      req_pulse = (k < 3) ? 4'b0100 : 4'b0000;
      chk($sformatf("t2_req_k%0d", k), 32'(req[2]), (k == 2 || k == 4 || k == 6) ? 1 : 0);
      if (k == 3) chk("t2_cnt_peak", cnt_of(2), 3);
      if (k == 8) chk("t2_cnt_done", cnt_of(2), 0);
    end

    // saturation and overflow on requester 1
    do_reset();
    req_pulse = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 8) req_pulse = '0;
      if (k == 7) begin chk("t3_cnt7", cnt_of(1), 7); chk("t3_ovf_pre", 32'(ovf[1]), 0); end
      if (k == 8) begin chk("t3_cnt_sat", cnt_of(1), 7); chk("t3_ovf_set", 32'(ovf[1]), 1); end
    end
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("t3_ovf_clr", 32'(ovf[1]), 0);

    // grant timeout retry
    do_reset();
    req_pulse = 4'b0001;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      req_pulse = '0;
      chk($sformatf("t4_req_k%0d", k), 32'(req[0]), (k == 2 || k == 19 || k == 36) ? 1 : 0);
      if (k == 18) chk("t4_starve_pre", 32'(starve[0]), 0);
      if (k == 19) chk("t4_starve_set", 32'(starve[0]), 1);
      if (k == 40) chk("t4_cnt", cnt_of(0), 1);
    end

    // spurious grant in IDLE, then pulse+grant coincident in WAIT
    do_reset();
    grnt = 4'b1000;
    cycle();
    grnt = '0;
    chk("t5_spur", 32'(spur_gnt[3]), 1);
    chk("t5_cnt_idle", cnt_of(3), 0);
    req_pulse = 4'b1000;
    cycle();
    cycle();
    req_pulse = '0;
    cycle();
    chk("t5_cnt_wait", cnt_of(3), 2);
    req_pulse = 4'b1000; grnt = 4'b1000;
    cycle();
    req_pulse = '0; grnt = '0;
    chk("t5_cnt_same", cnt_of(3), 2);
    chk("t5_reissue", 32'(req[3]), 1);

    // reset while waiting
    do_reset();
    req_pulse = 4'b0001;
    cycle(); cycle(); cycle();
    req_pulse = '0;
    chk("t6_cnt_pre", cnt_of(0), 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_cnt_rst", cnt_of(0), 0);
    chk("t6_req_rst", 32'(req), 0);
    chk("t6_flags_rst", 32'({ovf, starve, spur_gnt}), 0);
    grnt = 4'b0001;
    cycle();
    grnt = '0;
    chk("t6_late_spur", 32'(spur_gnt[0]), 1);

    // random traffic with a lossy echoing grant stage
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle();
      rst       = ($urandom_range(399) == 0);
      clr_err   = ($urandom_range(49) == 0);
      req_pulse = N'($urandom & $urandom);
      if ((n % 500) < 100) grnt = '0;
      else grnt = (prev_req & N'($urandom | $urandom)) | N'($urandom & $urandom & $urandom);
      prev_req = req;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
